// File: rtl/alu_lock_pkg.sv
// Shared types and known-answer-test constants for the ALU key loader.
// Optional build macro: ALU_KEY_LOCKOUT_EN adds the permanent LOCKOUT state.
package alu_lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    KAT_ADD  = 3'd2,
    KAT_SUB  = 3'd3,
    UNLOCKED = 3'd4
`ifdef ALU_KEY_LOCKOUT_EN
    , LOCKOUT = 3'd5
`endif
  } state_t;

  // Known-answer vectors: 0x0A + 0x02 = 0x0C, 0x0A - 0x02 = 0x08
  localparam logic [31:0] KAT_A   = 32'h0000_000A;
  localparam logic [31:0] KAT_B   = 32'h0000_0002;
  localparam logic [3:0]  OP_ADD  = 4'b0000;
  localparam logic [3:0]  OP_SUB  = 4'b0001;
  localparam logic [31:0] EXP_ADD = 32'h0000_000C;
  localparam logic [31:0] EXP_SUB = 32'h0000_0008;

endpackage

// File: rtl/key_shift_rx.sv
// Serial key receiver: MSB-first shift register with bit counter.
// `cand` is the key including the bit offered this cycle, so the caller can
// capture the full key on the same edge that accepts the last bit (`done`).
module key_shift_rx #(
  parameter int KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic [KEY_W-1:0] cand,
  output logic             done
);

  localparam int CW = $clog2(KEY_W + 1);

  logic [KEY_W-1:0] shreg;
  logic [CW-1:0]    cnt;

  assign cand = {shreg[KEY_W-2:0], sdi};
  assign done = sdi_valid && !clr && (cnt == CW'(KEY_W - 1));

  // Shift in valid bits; clear wins over a simultaneous valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (sdi_valid) begin
      shreg <= cand;
      cnt   <= done ? '0 : cnt + CW'(1);
    end else begin
      shreg <= shreg;
      cnt   <= cnt;
    end
  end

endmodule

// File: rtl/alu_key_loader.sv
// Key delivery and known-answer self-test for the logic-locked ALU.
// Optional build macro: ALU_KEY_LOCKOUT_EN (reaching MAX_FAIL failures locks
// the block until reset); without it retries are unlimited and lockout is 0.
module alu_key_loader
  import alu_lock_pkg::*;
#(
  parameter int KEY_W    = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_FAIL = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_sdi,
  input  logic                          key_sdi_valid,
  input  logic                          key_clr,
  input  logic [DATA_W-1:0]             alu_result,
  output logic [KEY_W-1:0]              key_out,
  output logic                          kat_sel,
  output logic [DATA_W-1:0]             kat_a,
  output logic [DATA_W-1:0]             kat_b,
  output logic [3:0]                    kat_op,
  output logic                          unlocked,
  output logic                          busy,
  output logic                          key_err,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic                          lockout
);

  localparam int FCW = $clog2(MAX_FAIL + 1);

  state_t            state, state_nxt;
  logic              accepting, rx_clr, shift_en, rx_done;
  logic [KEY_W-1:0]  rx_cand;
  logic              add_ok, kat_pass, kat_fail;
  logic [FCW-1:0]    fail_cnt_sat;

  logic [KEY_W-1:0]  key_out_nxt;
  logic              kat_sel_nxt, unlocked_nxt, busy_nxt, key_err_nxt;
  logic [DATA_W-1:0] kat_a_nxt, kat_b_nxt;
  logic [3:0]        kat_op_nxt;
  logic [FCW-1:0]    fail_cnt_nxt;

  // Key bits are only taken while no self-test or lockout is in progress
  assign accepting = (state == IDLE) || (state == SHIFT) || (state == UNLOCKED);
`ifdef ALU_KEY_LOCKOUT_EN
  assign rx_clr = key_clr && (state != LOCKOUT);
`else
  assign rx_clr = key_clr;
`endif
  assign shift_en = key_sdi_valid && accepting;

  key_shift_rx #(.KEY_W(KEY_W)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .clr       (rx_clr),
    .sdi       (key_sdi),
    .sdi_valid (shift_en),
    .cand      (rx_cand),
    .done      (rx_done)
  );

  // Both KAT vectors must match; a mid-test clear never counts as a failure
  assign kat_pass     = add_ok && (alu_result == DATA_W'(EXP_SUB));
  assign kat_fail     = (state == KAT_SUB) && !key_clr && !kat_pass;
  assign fail_cnt_sat = (fail_cnt == FCW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FCW'(1);

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, UNLOCKED, SHIFT: begin
        if (key_clr) begin
          state_nxt = IDLE;
        end else if (rx_done) begin
          state_nxt = KAT_ADD;
        end else if (shift_en) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = state;
        end
      end
      KAT_ADD: begin
        state_nxt = key_clr ? IDLE : KAT_SUB;
      end
      KAT_SUB: begin
        if (key_clr) begin
          state_nxt = IDLE;
        end else if (kat_pass) begin
          state_nxt = UNLOCKED;
        end else begin
`ifdef ALU_KEY_LOCKOUT_EN
          state_nxt = (fail_cnt_sat == FCW'(MAX_FAIL)) ? LOCKOUT : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef ALU_KEY_LOCKOUT_EN
      LOCKOUT: begin
        state_nxt = LOCKOUT;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Next output values, derived from the state being entered
  always_comb begin
    kat_sel_nxt  = 1'b0;
    kat_a_nxt    = '0;
    kat_b_nxt    = '0;
    kat_op_nxt   = OP_ADD;
    busy_nxt     = 1'b0;
    unlocked_nxt = 1'b0;
    key_out_nxt  = key_out;
    key_err_nxt  = kat_fail;
    fail_cnt_nxt = kat_fail ? fail_cnt_sat : fail_cnt;
    case (state_nxt)
      SHIFT: begin
        busy_nxt = 1'b1;
      end
      KAT_ADD: begin
        kat_sel_nxt = 1'b1;
        kat_a_nxt   = DATA_W'(KAT_A);
        kat_b_nxt   = DATA_W'(KAT_B);
        kat_op_nxt  = OP_ADD;
        busy_nxt    = 1'b1;
        key_out_nxt = rx_cand;
      end
      KAT_SUB: begin
        kat_sel_nxt = 1'b1;
        kat_a_nxt   = DATA_W'(KAT_A);
        kat_b_nxt   = DATA_W'(KAT_B);
        kat_op_nxt  = OP_SUB;
        busy_nxt    = 1'b1;
      end
      UNLOCKED: begin
        unlocked_nxt = 1'b1;
      end
      default: begin
        // IDLE (and LOCKOUT): no key is applied to the ALU
        key_out_nxt = '0;
      end
    endcase
  end

  // State, ADD-vector verdict and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      add_ok   <= 1'b0;
      key_out  <= '0;
      kat_sel  <= 1'b0;
      kat_a    <= '0;
      kat_b    <= '0;
      kat_op   <= 4'b0000;
      unlocked <= 1'b0;
      busy     <= 1'b0;
      key_err  <= 1'b0;
      fail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      add_ok   <= (state == KAT_ADD) ? (alu_result == DATA_W'(EXP_ADD)) : add_ok;
      key_out  <= key_out_nxt;
      kat_sel  <= kat_sel_nxt;
      kat_a    <= kat_a_nxt;
      kat_b    <= kat_b_nxt;
      kat_op   <= kat_op_nxt;
      unlocked <= unlocked_nxt;
      busy     <= busy_nxt;
      key_err  <= key_err_nxt;
      fail_cnt <= fail_cnt_nxt;
    end
  end

`ifdef ALU_KEY_LOCKOUT_EN
  // Lockout flag follows the LOCKOUT state, held until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockout <= 1'b0;
    end else begin
      lockout <= (state_nxt == LOCKOUT);
    end
  end
`else
  assign lockout = 1'b0;
`endif

endmodule

// File: doc/alu_key_loader.md
# alu_key_loader

Key-delivery and self-test controller for the 32-bit logic-locked ALU: receives the 8-bit unlock key serially from secure storage, applies it to the ALU key port and proves it with a two-vector known-answer test (KAT). It grants `unlocked` only when both KAT results match. On a failed KAT it clears the key and counts the failure. It sits between the key store and the locked ALU, and muxes the ALU operand and opcode inputs during self-test.

## Interface
- `KEY_W`, 8, key width; must match the locked ALU key port
- `DATA_W`, 32, ALU operand/result width
- `MAX_FAIL`, 3, failed-KAT limit; used by lockout and for counter saturation
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `key_sdi` in 1: serial key bit, MSB first
- `key_sdi_valid` in 1: `key_sdi` is accepted on this edge
- `key_clr` in 1: synchronous abort or relock
- `alu_result` in DATA_W: `ALU_Out` of the locked ALU (combinational)
- `key_out` out KEY_W: drives the ALU `key` port
- `kat_sel` out 1: system mux selects `kat_a`, `kat_b` and `kat_op` into the ALU
- `kat_a` out DATA_W: KAT operand A
- `kat_b` out DATA_W: KAT operand B
- `kat_op` out 4: KAT ALU opcode
- `unlocked` out 1: key verified and applied
- `busy` out 1: high in SHIFT, KAT_ADD and KAT_SUB
- `key_err` out 1: one-cycle pulse on KAT failure
- `fail_cnt` out `$clog2(MAX_FAIL+1)`: failed-KAT count
- `lockout` out 1: permanent lockout (macro only; otherwise tied 0)

## Operation
- States: IDLE, SHIFT, KAT_ADD, KAT_SUB, UNLOCKED, LOCKOUT.
- Reset values:
  - All outputs 0, `key_out` = 0, state IDLE.
  - Shift register and bit counter cleared.
- IDLE / UNLOCKED, on `key_sdi_valid`:
  - The bit shifts in and the state goes to SHIFT with count = 1.
  - `unlocked` drops on the same edge.
  - `key_out` holds its old value until the KAT starts.
- SHIFT:
  - Each valid bit shifts in, LSB-side insert.
  - Gaps in `key_sdi_valid` are allowed; there is no timeout.
  - The KEY_W-th bit moves the state to KAT_ADD.
- KAT_ADD:
  - `kat_sel` = 1, `key_out` = candidate, `kat_a` = 0x0A, `kat_b` = 0x02, `kat_op` = 4'b0000.
  - Expected result 0x0000000C.
- KAT_SUB:
  - Same key, `kat_op` = 4'b0001.
  - Expected result 0x00000008.
- Pass (both results matched):
  - State goes to UNLOCKED, `unlocked` = 1, `kat_sel` = 0, `key_out` retains the candidate.
  - `fail_cnt` is unchanged.
- Fail:
  - `key_out` = 0, `kat_sel` = 0, `key_err` pulses, `fail_cnt` increments (saturates at MAX_FAIL).
  - State goes to IDLE, or to LOCKOUT per Configuration.
- `key_clr`, any state except LOCKOUT:
  - State goes to IDLE.
  - Counter, shift register, `key_out`, `unlocked` and `kat_sel` are cleared.
  - No failure is counted, including when `key_clr` arrives mid-KAT.
  - `key_clr` wins over a simultaneous `key_sdi_valid`; that bit is dropped.
- `rst` mid-operation: immediate return to reset values, including `fail_cnt`.

## Timing
- All outputs are registered.
- Edge E0 (accepts the last key bit): enter KAT_ADD and load the ADD vectors.
- E1: sample `alu_result`, enter KAT_SUB, load the SUB vector.
- E2: sample `alu_result`; `unlocked` or `key_err` is visible after E2.
- `kat_sel` is high for exactly 2 cycles.
- The ALU path from the registered KAT outputs to the `alu_result` sample is one full cycle.
- A key load takes a minimum of KEY_W + 2 cycles.

## Configuration
- `ALU_KEY_LOCKOUT_EN` defined:
  - The failure that brings `fail_cnt` to MAX_FAIL enters LOCKOUT.
  - In LOCKOUT, `lockout` = 1 and `key_out` = 0; all inputs are ignored until `rst`.
- Undefined:
  - No LOCKOUT state; `lockout` is tied 0.
  - Retries are unlimited and `fail_cnt` saturates at MAX_FAIL.

## Structure
- Package `alu_lock_pkg` holds:
  - the state enum;
  - the KAT constants: KAT_A = 0x0A, KAT_B = 0x02, OP_ADD = 4'b0000, OP_SUB = 4'b0001, EXP_ADD = 0x0C, EXP_SUB = 0x08.
- Sub-module `key_shift_rx` contains the serial shift register, bit counter, clear input and a done pulse.
- The FSM and KAT compare live in the top level.

## Test plan
The bench instantiates the real locked ALU with the system mux.
1. Assert `rst` -> all outputs 0; `busy` = 0; state IDLE.
2. Shift 8'b00100110 MSB first -> `kat_sel` high 2 cycles with A = 0x0A, B = 0x02, op 0 then 1; `unlocked` = 1 after E2; `key_out` = 0x26.
3. Shift 8'b00000110 -> KAT mismatch; `key_err` pulses 1 cycle; `key_out` = 0; `fail_cnt` = 1; state IDLE.
4. With `ALU_KEY_LOCKOUT_EN`: 3 wrong keys -> `lockout` = 1; a following correct key is ignored; `rst` clears `lockout` and `fail_cnt`.
5. 4 bits, then `key_clr` asserted together with `key_sdi_valid` -> bit dropped, counter cleared; next full 0x26 -> `unlocked`; `key_clr` during KAT_SUB -> `fail_cnt` unchanged.
6. Without the macro: 5 wrong keys then 0x26 -> `fail_cnt` = 3 (saturated); `unlocked` = 1.
